// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module  : ctrl_pkg
// Brief   : Opcode/field constants and control-output encodings for ctrl_unit.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package ctrl_pkg;

  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [2:0] IMM_NONE = 3'b000;
  localparam logic [2:0] IMM_U    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_S    = 3'b011;
  localparam logic [2:0] IMM_I    = 3'b100;
  localparam logic [2:0] IMM_J    = 3'b101;

  localparam logic [2:0] CMP_EQ  = 3'b000;
  localparam logic [2:0] CMP_NE  = 3'b001;
  localparam logic [2:0] CMP_LT  = 3'b010;
  localparam logic [2:0] CMP_GE  = 3'b011;
  localparam logic [2:0] CMP_LTU = 3'b100;
  localparam logic [2:0] CMP_GEU = 3'b101;

  localparam logic [1:0] PC_ALU  = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_HOLD = 2'b10;

  localparam logic [1:0] RD_IMM = 2'b00;
  localparam logic [1:0] RD_PC4 = 2'b01;
  localparam logic [1:0] RD_ALU = 2'b10;
  localparam logic [1:0] RD_MEM = 2'b11;

  localparam logic [1:0] INST_MEM  = 2'b00;
  localparam logic [1:0] INST_NOP  = 2'b01;
  localparam logic [1:0] INST_HOLD = 2'b10;

  localparam logic [2:0] SEL_WORD = 3'b010;

endpackage

`default_nettype wire

// File: rtl/ctrl_load_phase.sv
// ============================================================================
// Module  : ctrl_load_phase
// Brief   : One-bit LOAD phase tracker (0 = address phase, 1 = data phase).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ctrl_load_phase (
  input  logic clk,
  input  logic rst,
  input  logic is_load,
  output logic load_phase
);

  logic load_phase_d;
  logic load_phase_q;

  // Back-to-back LOADs keep toggling, so the 0,1,0,1 sequence runs unbroken.
  always_comb begin
    load_phase_d = is_load ? ~load_phase_q : 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_phase_q <= 1'b0;
    end else begin
      load_phase_q <= load_phase_d;
    end
  end

  assign load_phase = load_phase_q;

endmodule

`default_nettype wire

// File: rtl/ctrl_unit.sv
// ============================================================================
// Module  : ctrl_unit
// Brief   : RV32I main decoder; all outputs combinational from the instruction
//           fields and the LOAD phase bit. Optional macro: CTRL_AUIPC_EN.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ctrl_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       b,
  output logic [2:0] imm_type,
  output logic [1:0] inst_sel,
  output logic       reg_wr,
  output logic [3:0] alu_op,
  output logic [2:0] cmp_op,
  output logic [1:0] pc_sel,
  output logic       mem_sel,
  output logic [1:0] rd_sel,
  output logic       alu1_sel,
  output logic       alu2_sel,
  output logic [2:0] sel_type,
  output logic       we
);

  logic w_is_load;
  logic w_load_phase;

  assign w_is_load = (opcode == OPC_LOAD);

  ctrl_load_phase u_load_phase (
    .clk        (clk),
    .rst        (rst),
    .is_load    (w_is_load),
    .load_phase (w_load_phase)
  );

  always_comb begin
    alu_op = ALU_ADD;
    if (opcode == OPC_OP || opcode == OPC_OP_IMM) begin
      case (func3)
        F3_ADD:  alu_op = (opcode == OPC_OP && func7 == F7_ALT) ? ALU_SUB : ALU_ADD;
        F3_SLL:  alu_op = ALU_SLL;
        F3_SLT:  alu_op = ALU_SLT;
        F3_SLTU: alu_op = ALU_SLTU;
        F3_XOR:  alu_op = ALU_XOR;
        F3_SR:   alu_op = func7[5] ? ALU_SRA : ALU_SRL;
        F3_OR:   alu_op = ALU_OR;
        F3_AND:  alu_op = ALU_AND;
        default: alu_op = ALU_ADD;
      endcase
    end
  end

  // Comparator op ignores opcode; it only matters when a BRANCH consumes it.
  always_comb begin
    case (func3)
      F3_BEQ:  cmp_op = CMP_EQ;
      F3_BNE:  cmp_op = CMP_NE;
      F3_BLT:  cmp_op = CMP_LT;
      F3_BGE:  cmp_op = CMP_GE;
      F3_BLTU: cmp_op = CMP_LTU;
      F3_BGEU: cmp_op = CMP_GEU;
      default: cmp_op = CMP_EQ;
    endcase
  end

  always_comb begin
    imm_type = IMM_NONE;
    inst_sel = INST_MEM;
    reg_wr   = 1'b0;
    pc_sel   = PC_INC;
    mem_sel  = 1'b0;
    rd_sel   = RD_ALU;
    alu1_sel = 1'b0;
    alu2_sel = 1'b1;
    sel_type = SEL_WORD;
    we       = 1'b0;
    case (opcode)
      OPC_OP: begin
        reg_wr   = 1'b1;
        alu2_sel = 1'b0;
      end
      OPC_OP_IMM: begin
        imm_type = IMM_I;
        reg_wr   = 1'b1;
      end
      // Address phase holds PC and instruction while the port serves data.
      OPC_LOAD: begin
        imm_type = IMM_I;
        rd_sel   = RD_MEM;
        sel_type = func3;
        reg_wr   = w_load_phase;
        mem_sel  = ~w_load_phase;
        pc_sel   = w_load_phase ? PC_INC : PC_HOLD;
        inst_sel = w_load_phase ? INST_NOP : INST_HOLD;
      end
      OPC_STORE: begin
        imm_type = IMM_S;
        sel_type = func3;
        we       = 1'b1;
        mem_sel  = 1'b1;
        inst_sel = INST_NOP;
      end
      OPC_BRANCH: begin
        imm_type = IMM_B;
        alu1_sel = 1'b1;
        pc_sel   = b ? PC_ALU : PC_INC;
        inst_sel = b ? INST_NOP : INST_MEM;
      end
      OPC_JAL: begin
        imm_type = IMM_J;
        alu1_sel = 1'b1;
        reg_wr   = 1'b1;
        rd_sel   = RD_PC4;
        pc_sel   = PC_ALU;
        inst_sel = INST_NOP;
      end
      OPC_JALR: begin
        imm_type = IMM_I;
        reg_wr   = 1'b1;
        rd_sel   = RD_PC4;
        pc_sel   = PC_ALU;
        inst_sel = INST_NOP;
      end
      OPC_LUI: begin
        imm_type = IMM_U;
        reg_wr   = 1'b1;
        rd_sel   = RD_IMM;
      end
`ifdef CTRL_AUIPC_EN
      OPC_AUIPC: begin
        imm_type = IMM_U;
        alu1_sel = 1'b1;
        reg_wr   = 1'b1;
      end
`endif
      default: begin
        imm_type = IMM_NONE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ctrl_unit.sv
// ============================================================================
// Module  : tb_ctrl_unit
// Brief   : Scoreboard bench for ctrl_unit with a rule-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       b;
  logic [2:0] imm_type;
  logic [1:0] inst_sel;
  logic       reg_wr;
  logic [3:0] alu_op;
  logic [2:0] cmp_op;
  logic [1:0] pc_sel;
  logic       mem_sel;
  logic [1:0] rd_sel;
  logic       alu1_sel;
  logic       alu2_sel;
  logic [2:0] sel_type;
  logic       we;

  ctrl_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7), .b(b),
    .imm_type(imm_type), .inst_sel(inst_sel), .reg_wr(reg_wr), .alu_op(alu_op),
    .cmp_op(cmp_op), .pc_sel(pc_sel), .mem_sel(mem_sel), .rd_sel(rd_sel),
    .alu1_sel(alu1_sel), .alu2_sel(alu2_sel), .sel_type(sel_type), .we(we)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [23:0] exp;
  } exp_t;

  exp_t q[$];
  event chk;
  int   total = 0;
  int   bad   = 0;
  bit   mphase = 1'b0;

  // Opcode values written out as plain numbers, independent of the RTL package.
  localparam logic [4:0] T_OP = 5'd12, T_OPI = 5'd4, T_LD = 5'd0, T_ST = 5'd8,
                         T_BR = 5'd24, T_JAL = 5'd27, T_JALR = 5'd25,
                         T_LUI = 5'd13, T_AUI = 5'd5;

  function automatic logic [23:0] model(input logic [4:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic bb,
                                        input bit ph);
    logic [3:0] alu_tab [8];
    logic [2:0] cmp_tab [8];
    logic [2:0] e_imm, e_cmp, e_sel;
    logic [1:0] e_inst, e_pc, e_rd;
    logic [3:0] e_alu;
    logic e_rw, e_mem, e_a1, e_a2, e_we;
    bit aui;
    alu_tab = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd2, 4'd6, 4'd3, 4'd4};
    cmp_tab = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd2, 3'd3, 3'd4, 3'd5};
`ifdef CTRL_AUIPC_EN
    aui = (op == T_AUI);
`else
    aui = 1'b0;
`endif
    e_imm = (op == T_LUI || aui) ? 3'd1 :
            (op == T_OPI || op == T_LD || op == T_JALR) ? 3'd4 :
            (op == T_ST) ? 3'd3 : (op == T_BR) ? 3'd2 : (op == T_JAL) ? 3'd5 : 3'd0;
    if (op == T_ST || op == T_JAL || op == T_JALR || (op == T_BR && bb) || (op == T_LD && ph))
      e_inst = 2'd1;
    else if (op == T_LD)
      e_inst = 2'd2;
    else
      e_inst = 2'd0;
    e_rw  = (op == T_OP || op == T_OPI || op == T_LUI || aui || op == T_JAL || op == T_JALR) ||
            (op == T_LD && ph);
    e_alu = 4'd0;
    if (op == T_OP || op == T_OPI) begin
      e_alu = alu_tab[f3];
      if (f3 == 3'd0 && op == T_OP && f7 == 7'h20) e_alu = 4'd1;
      if (f3 == 3'd5 && f7[5]) e_alu = 4'd7;
    end
    e_cmp = cmp_tab[f3];
    if (op == T_JAL || op == T_JALR || (op == T_BR && bb)) e_pc = 2'd0;
    else if (op == T_LD && !ph) e_pc = 2'd2;
    else e_pc = 2'd1;
    e_mem = (op == T_ST) || (op == T_LD && !ph);
    e_rd  = (op == T_LUI) ? 2'd0 : (op == T_JAL || op == T_JALR) ? 2'd1 :
            (op == T_LD) ? 2'd3 : 2'd2;
    e_a1  = (op == T_JAL || op == T_BR || aui);
    e_a2  = (op != T_OP);
    e_sel = (op == T_LD || op == T_ST) ? f3 : 3'd2;
    e_we  = (op == T_ST);
    return {e_imm, e_inst, e_rw, e_alu, e_cmp, e_pc, e_mem, e_rd, e_a1, e_a2, e_sel, e_we};
  endfunction

  always begin
    exp_t        e;
    logic [23:0] act;
    @(chk);
    while (q.size() > 0) begin
      e   = q.pop_front();
      act = {imm_type, inst_sel, reg_wr, alu_op, cmp_op, pc_sel, mem_sel, rd_sel,
             alu1_sel, alu2_sel, sel_type, we};
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got=%06h expected=%06h (op=%b f3=%b f7=%b b=%b)",
                 e.name, act, e.exp, opcode, func3, func7, b);
      end
    end
  end

  task automatic drive(input logic [4:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic bb);
    opcode = op; func3 = f3; func7 = f7; b = bb;
  endtask

  task automatic push(input string nm);
    exp_t e;
    e.name = nm;
    e.exp  = model(opcode, func3, func7, b, mphase);
    q.push_back(e);
  endtask

  // Called at posedge+1: drive, check at +3, advance model across the next edge.
  task automatic step(input string nm, input logic [4:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic bb);
    drive(op, f3, f7, bb);
    push(nm);
    #2 -> chk;
    @(posedge clk);
    mphase = (rst && opcode == T_LD) ? ~mphase : 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(T_LD, 3'd2, 7'd0, 1'b0);
    @(posedge clk); #1;
    push("reset_load");
    #2 -> chk;
    @(posedge clk); #1;
    rst = 1'b1;

    step("load_ph0", T_LD, 3'd2, 7'd0, 1'b0);
    step("load_ph1", T_LD, 3'd2, 7'd0, 1'b0);
    step("op_sub",   T_OP,  3'd0, 7'h20, 1'b0);
    step("op_add",   T_OP,  3'd0, 7'h00, 1'b0);
    step("opi_add",  T_OPI, 3'd0, 7'h20, 1'b0);
    step("op_srl",   T_OP,  3'd5, 7'h00, 1'b0);
    step("op_sra",   T_OP,  3'd5, 7'h20, 1'b0);
    step("op_slt",   T_OP,  3'd2, 7'h00, 1'b0);
    step("op_xor",   T_OP,  3'd4, 7'h00, 1'b0);
    step("op_sll",   T_OPI, 3'd1, 7'h00, 1'b0);
    step("lui",      T_LUI, 3'd3, 7'h11, 1'b0);
    step("store",    T_ST,  3'd1, 7'h00, 1'b0);
    step("jal",      T_JAL, 3'd0, 7'h00, 1'b1);
    step("jalr",     T_JALR,3'd0, 7'h00, 1'b0);
    step("br_nt",    T_BR,  3'd6, 7'h00, 1'b0);
    step("br_t",     T_BR,  3'd5, 7'h00, 1'b1);
    step("br_eq",    T_BR,  3'd0, 7'h00, 1'b1);
    step("auipc",    T_AUI, 3'd0, 7'h00, 1'b0);
    step("unknown",  5'd31, 3'd3, 7'h7f, 1'b1);

    step("b2b_0", T_LD, 3'd0, 7'd0, 1'b0);
    step("b2b_1", T_LD, 3'd0, 7'd0, 1'b0);
    step("b2b_2", T_LD, 3'd4, 7'd0, 1'b0);
    step("b2b_3", T_LD, 3'd4, 7'd0, 1'b0);
    step("after_load", T_OP, 3'd7, 7'd0, 1'b0);

    step("mid_ph0", T_LD, 3'd1, 7'd0, 1'b0);
    drive(T_LD, 3'd1, 7'd0, 1'b0);
    push("mid_ph1");
    #2 -> chk;
    #2 rst = 1'b0;
    mphase = 1'b0;
    push("rst_mid_load");
    #1 -> chk;
    @(posedge clk); #1;
    rst = 1'b1;
    step("restart_ph0", T_LD, 3'd1, 7'd0, 1'b0);
    step("restart_ph1", T_LD, 3'd1, 7'd0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [4:0] op;
      logic [6:0] f7;
      logic [4:0] ops [9];
      ops = '{T_OP, T_OPI, T_LD, T_ST, T_BR, T_JAL, T_JALR, T_LUI, T_AUI};
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops[$urandom_range(0, 8)];
      case ($urandom_range(0, 2))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      step("random", op, 3'($urandom), f7, 1'($urandom));
    end

    #5;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got=%0d pending expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
